apple_spawner: RTL



---
 rtl/apple_pkg.sv | 27 ++
 rtl/apple_lfsr.sv | 22 ++
 rtl/apple_spawner.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/apple_pkg.sv
// rtl/apple_pkg.sv - shared types, widths and LFSR helper for the apple spawner
package apple_pkg;

  localparam int X_W    = 7;
  localparam int Y_W    = 6;
  localparam int LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
  localparam logic [LFSR_W-1:0] DEF_LFSR_SEED = 16'hACE1;

  localparam int DEF_GRID_COLS = 64;
  localparam int DEF_GRID_ROWS = 48;
  localparam int DEF_MAX_TRIES = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_QUERY = 2'd2,
    S_SCAN  = 2'd3
  } state_e;

  // Galois step: shift right, fold the taps back in when a one falls out
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/apple_lfsr.sv
// rtl/apple_lfsr.sv - free-running 16-bit Galois LFSR, seeded on reset
module apple_lfsr
  import apple_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_LFSR_SEED
) (
  input  logic              pclk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] state_q;

  // advance every cycle so request timing feeds into the candidate sequence
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= lfsr_next(state_q);
  end

  assign lfsr_o = state_q;

endmodule

// File: rtl/apple_spawner.sv
// rtl/apple_spawner.sv - picks a free grid cell for the apple; APPLE_SPAWN_SCAN_EN adds a linear scan fallback
module apple_spawner
  import apple_pkg::*;
#(
  parameter int              GRID_COLS = DEF_GRID_COLS,
  parameter int              GRID_ROWS = DEF_GRID_ROWS,
  parameter int              MAX_TRIES = DEF_MAX_TRIES,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic           pclk,
  input  logic           rst_n,
  input  logic           spawn_req,
  output logic           busy,
  output logic           occ_req,
  output logic [X_W-1:0] q_x,
  output logic [Y_W-1:0] q_y,
  input  logic           occ_ack,
  input  logic           occ_hit,
  output logic [X_W-1:0] apple_x,
  output logic [Y_W-1:0] apple_y,
  output logic           apple_valid,
  output logic           spawn_done,
  output logic           spawn_fail
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic [LFSR_W-1:0] lfsr;
  logic [X_W-1:0]    cand_x;
  logic [Y_W-1:0]    cand_y;
  logic              cand_ok;
  logic              unused_lfsr_hi;

  state_e            state_q;
  logic [TRY_W-1:0]  tries_q;
  logic              busy_q, occ_req_q, apple_valid_q, spawn_done_q, spawn_fail_q;
  logic [X_W-1:0]    q_x_q, apple_x_q;
  logic [Y_W-1:0]    q_y_q, apple_y_q;

  apple_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr)
  );

  assign cand_x         = lfsr[6:0];
  assign cand_y         = lfsr[12:7];
  assign unused_lfsr_hi = ^lfsr[15:13];
  assign cand_ok        = ({1'b0, cand_x} < 8'(GRID_COLS)) && ({1'b0, cand_y} < 7'(GRID_ROWS));

`ifdef APPLE_SPAWN_SCAN_EN
  localparam int CELLS  = GRID_COLS * GRID_ROWS;
  localparam int SCAN_W = $clog2(CELLS + 1);

  logic [SCAN_W-1:0] scan_cnt_q;
  logic [X_W-1:0]    scan_x_d;
  logic [Y_W-1:0]    scan_y_d;

  // raster-order successor of the cell currently being queried
  always_comb begin
    scan_x_d = q_x_q + 7'd1;
    scan_y_d = q_y_q;
    if ({1'b0, q_x_q} == 8'(GRID_COLS - 1)) begin
      scan_x_d = '0;
      scan_y_d = ({1'b0, q_y_q} == 7'(GRID_ROWS - 1)) ? '0 : q_y_q + 6'd1;
    end
  end
`endif

  // spawn sequencer: draw, query, commit or give up; all outputs registered here
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tries_q       <= '0;
      busy_q        <= 1'b0;
      occ_req_q     <= 1'b0;
      q_x_q         <= '0;
      q_y_q         <= '0;
      apple_x_q     <= '0;
      apple_y_q     <= '0;
      apple_valid_q <= 1'b0;
      spawn_done_q  <= 1'b0;
      spawn_fail_q  <= 1'b0;
`ifdef APPLE_SPAWN_SCAN_EN
      scan_cnt_q    <= '0;
`endif
    end else begin
      spawn_done_q <= 1'b0;
      spawn_fail_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (spawn_req) begin
            state_q <= S_GEN;
            busy_q  <= 1'b1;
            tries_q <= '0;
          end
        end
        S_GEN: begin
          // out-of-grid draws just wait for the next LFSR value
          if (cand_ok) begin
            q_x_q   <= cand_x;
            q_y_q   <= cand_y;
            state_q <= S_QUERY;
          end
        end
        S_QUERY: begin
          // first cycle only raises the request so q_x/q_y lead occ_req
          if (!occ_req_q) begin
            occ_req_q <= 1'b1;
          end else if (occ_ack) begin
            if (!occ_hit) begin
              apple_x_q     <= q_x_q;
              apple_y_q     <= q_y_q;
              apple_valid_q <= 1'b1;
              spawn_done_q  <= 1'b1;
              occ_req_q     <= 1'b0;
              busy_q        <= 1'b0;
              state_q       <= S_IDLE;
            end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
`ifdef APPLE_SPAWN_SCAN_EN
              // keep the request up and walk on from the last queried cell
              q_x_q      <= scan_x_d;
              q_y_q      <= scan_y_d;
              scan_cnt_q <= '0;
              state_q    <= S_SCAN;
`else
              spawn_fail_q <= 1'b1;
              occ_req_q    <= 1'b0;
              busy_q       <= 1'b0;
              state_q      <= S_IDLE;
`endif
            end else begin
              tries_q   <= tries_q + TRY_W'(1);
              occ_req_q <= 1'b0;
              state_q   <= S_GEN;
            end
          end
        end
`ifdef APPLE_SPAWN_SCAN_EN
        S_SCAN: begin
          if (occ_ack) begin
            if (!occ_hit) begin
              apple_x_q     <= q_x_q;
              apple_y_q     <= q_y_q;
              apple_valid_q <= 1'b1;
              spawn_done_q  <= 1'b1;
              occ_req_q     <= 1'b0;
              busy_q        <= 1'b0;
              state_q       <= S_IDLE;
            end else if (scan_cnt_q == SCAN_W'(CELLS - 1)) begin
              spawn_fail_q <= 1'b1;
              occ_req_q    <= 1'b0;
              busy_q       <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
              q_x_q      <= scan_x_d;
              q_y_q      <= scan_y_d;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign occ_req     = occ_req_q;
  assign q_x         = q_x_q;
  assign q_y         = q_y_q;
  assign apple_x     = apple_x_q;
  assign apple_y     = apple_y_q;
  assign apple_valid = apple_valid_q;
  assign spawn_done  = spawn_done_q;
  assign spawn_fail  = spawn_fail_q;

endmodule
